instr_fetch: RTL and testbench

//   Fetch stage directly upstream of the instruction decoder. Holds the PC, issues

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_buf.sv | 65 ++++++
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage.
// The HALT opcode value comes from the shared instruction-set definitions.
// If no such definition has been included, a local fallback is used.
// The FETCH_HALT_EN macro is consumed by instr_fetch.sv, not by this package.
`ifndef OP_HALT
`define OP_HALT 4'hF
`endif

package instr_fetch_pkg;

    // S_HALT is only ever entered when FETCH_HALT_EN is defined.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_buf.sv
// fetch_buf: small synchronous FIFO of {pc, instr} pairs feeding the decoder.
// The head entry is presented combinationally from registers, so a word pushed
// on one edge is visible on rd_* in the following cycle. Flush outranks push and
// pop. A push and a pop in the same cycle are accepted even when full.
module fetch_buf #(
    parameter int BUF_DEPTH = 2,
    parameter int PC_W      = 8,
    parameter int INSTR_W   = 16,
    localparam int AW       = $clog2(BUF_DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [PC_W-1:0]    wr_pc,
    input  logic [INSTR_W-1:0] wr_instr,
    output logic [PC_W-1:0]    rd_pc,
    output logic [INSTR_W-1:0] rd_instr,
    output logic               full,
    output logic               empty,
    output logic [CW-1:0]      count
);

    logic [PC_W+INSTR_W-1:0] mem_q [BUF_DEPTH];
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic                    push_ok;

    assign full    = (count_q == CW'(BUF_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // A push into a full buffer is only legal when the head leaves the same edge.
    assign push_ok = push & (~full | pop);

    assign {rd_pc, rd_instr} = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; entries cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {wr_pc, wr_instr};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, single-outstanding imem read FSM and fetch buffer
// between instruction memory and the decoder.
// Optional feature macro: FETCH_HALT_EN (stop fetching after an OP_HALT word).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter int              INSTR_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;               // address of current / next request
    logic            drop_q, drop_d;           // in-flight word belongs to a stale path
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;   // target held until the stale word returns

    logic            buf_push, buf_pop, buf_full, buf_empty;
    logic [CW-1:0]   buf_count, count_after;
    logic            ack_fire;

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = ~buf_empty;
    assign ack_fire    = imem_req & imem_ack;
    // Redirect flushes the buffer, so it suppresses both push and pop.
    assign buf_pop     = ~buf_empty & instr_ready & ~redirect;
    assign buf_push    = ack_fire & ~drop_q & ~redirect;
    assign count_after = buf_count + CW'(buf_push) - CW'(buf_pop);

`ifdef FETCH_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

    fetch_buf #(
        .BUF_DEPTH (BUF_DEPTH),
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (buf_push),
        .pop      (buf_pop),
        .flush    (redirect),
        .wr_pc    (pc_q),
        .wr_instr (imem_rdata),
        .rd_pc    (pc_out),
        .rd_instr (instr_out),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    // State, PC and drop bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    // Next-state logic: redirect first, then the normal request/ack flow.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        redir_pc_d = redir_pc_q;
        if (redirect) begin
            state_d = S_REQ;
            if (state_q == S_REQ && !imem_ack) begin
                // Keep the address stable until the stale request completes.
                drop_d     = 1'b1;
                redir_pc_d = redirect_pc;
            end else begin
                drop_d = 1'b0;
                pc_d   = redirect_pc;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!buf_full) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                            pc_d   = redir_pc_q;
                        end else begin
                            pc_d    = pc_q + PC_W'(1);
                            state_d = (count_after < CW'(BUF_DEPTH)) ? S_REQ : S_IDLE;
`ifdef FETCH_HALT_EN
                            if (imem_rdata[3:0] == `OP_HALT) begin
                                state_d = S_HALT;
                            end
`endif
                        end
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: randomized memory latency, decoder
// back-pressure and redirects against a sequence-level reference model.
`ifndef OP_HALT
`define OP_HALT 4'hF
`endif

module tb_instr_fetch;

    localparam int         PC_W      = 8;
    localparam int         INSTR_W   = 16;
    localparam int         BUF_DEPTH = 2;
    localparam logic [7:0] RESET_PC  = 8'h00;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic               instr_valid;
    logic               instr_ready = 1'b0;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               halted;

    always #5 clk = ~clk;

    instr_fetch #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
    );

    // Reference memory and model state
    logic [15:0] mem [256];
    logic [7:0]  exp_pc;
    bit          model_halted;
    logic [7:0]  log_q [$];
    int          deliveries;
    int          ack_count;
    int          lat_fixed;
    bit          req_active;
    int          wait_cnt;
    int          lat_cur;
    logic [7:0]  req_addr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, act as memory, score deliveries.
    task automatic tick(input bit rdy, input bit redir, input logic [7:0] rpc);
        @(negedge clk);
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (imem_req) begin
            if (!req_active) begin
                req_active = 1'b1;
                req_addr   = imem_addr;
                wait_cnt   = 0;
                lat_cur    = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            end
            if (wait_cnt >= lat_cur) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                check_eq("addr_stable", 32'(imem_addr), 32'(req_addr));
                req_active = 1'b0;
                ack_count++;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            req_active = 1'b0;
        end
        if (instr_valid && rdy && !redir) begin
            if (model_halted) begin
                check_eq("halt_no_more", 32'(instr_valid), 32'(0));
            end
            check_eq("deliv_pc", 32'(pc_out), 32'(exp_pc));
            check_eq("deliv_instr", 32'(instr_out), 32'(mem[exp_pc]));
            if (HALT_EN && mem[exp_pc][3:0] == `OP_HALT) begin
                model_halted = 1'b1;
            end
            log_q.push_back(pc_out);
            deliveries++;
            exp_pc = exp_pc + 8'd1;
        end
        if (redir) begin
            exp_pc       = rpc;
            model_halted = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"},    32'(imem_req),    32'(0));
        check_eq({tag, "_addr"},   32'(imem_addr),   32'(RESET_PC));
        check_eq({tag, "_valid"},  32'(instr_valid), 32'(0));
        check_eq({tag, "_instr"},  32'(instr_out),   32'(0));
        check_eq({tag, "_pc"},     32'(pc_out),      32'(0));
        check_eq({tag, "_halted"}, 32'(halted),      32'(0));
    endtask

    task automatic clear_model();
        exp_pc       = RESET_PC;
        model_halted = 1'b0;
        req_active   = 1'b0;
        wait_cnt     = 0;
        ack_count    = 0;
        imem_ack     = 1'b0;
        redirect     = 1'b0;
        log_q.delete();
    endtask

    task automatic do_reset(input bit check_vals);
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        if (check_vals) check_reset_values("rst");
        rst_n = 1'b1;
    endtask

    task automatic wait_log(input int n, input bit rdy);
        for (int k = 0; k < 300 && log_q.size() < n; k++) tick(rdy, 1'b0, 8'h00);
        check_eq("wait_log_timeout", 32'(log_q.size() >= n), 32'(1));
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (v[3:0] == `OP_HALT) v[3:0] = 4'hE;
            mem[i] = v[15:0];
        end
        deliveries = 0;
        lat_fixed  = 0;

        // Reset values, then back-pressure: decoder stalled for 10 cycles
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 8'h00);
        check_eq("full_acks", 32'(ack_count), 32'(BUF_DEPTH));
        check_eq("full_req_low", 32'(imem_req), 32'(0));
        check_eq("full_valid", 32'(instr_valid), 32'(1));
        check_eq("full_head_pc", 32'(pc_out), 32'(RESET_PC));

        // Zero-wait memory, ready=1: one instruction per cycle in steady state
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, 8'h00);
        d0 = deliveries;
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, 8'h00);
        check_eq("throughput", 32'(deliveries - d0), 32'(20));
        check_eq("seq_start", 32'(log_q[0]), 32'(RESET_PC));

        // 3-cycle memory, redirect to 8'h40 while a request waits
        lat_fixed = 3;
        for (int k = 0; k < 100; k++) begin
            tick(1'b1, 1'b0, 8'h00);
            if (req_active && !imem_ack && wait_cnt == 1) break;
        end
        check_eq("mid_wait_found", 32'(req_active && wait_cnt == 1), 32'(1));
        log_q.delete();
        tick(1'b1, 1'b1, 8'h40);
        tick(1'b1, 1'b0, 8'h00);
        check_eq("redir_flush_valid", 32'(instr_valid), 32'(0));
        wait_log(1, 1'b1);
        if (log_q.size() >= 1) check_eq("redir_first_pc", 32'(log_q[0]), 32'h40);

        // PC wrap FE, FF, 00, 01
        lat_fixed = 0;
        tick(1'b1, 1'b1, 8'hFE);
        log_q.delete();
        wait_log(4, 1'b1);
        if (log_q.size() >= 4) begin
            check_eq("wrap0", 32'(log_q[0]), 32'hFE);
            check_eq("wrap1", 32'(log_q[1]), 32'hFF);
            check_eq("wrap2", 32'(log_q[2]), 32'h00);
            check_eq("wrap3", 32'(log_q[3]), 32'h01);
        end

        // Randomized latency, back-pressure and redirects
        lat_fixed = -1;
        d0 = deliveries;
        for (int k = 0; k < 600; k++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 8'($urandom));
        end
        check_eq("rand_progress", 32'((deliveries - d0) > 100), 32'(1));
        check_eq("halted_zero", 32'(halted), 32'(0));

`ifdef FETCH_HALT_EN
        // HALT word at 8'h05 stops fetch until redirect
        begin
            logic [15:0] saved;
            saved = mem[5];
            mem[5] = {saved[15:4], `OP_HALT};
            lat_fixed = 0;
            do_reset(1'b0);
            for (int k = 0; k < 30; k++) tick(1'b1, 1'b0, 8'h00);
            check_eq("halt_count", 32'(log_q.size()), 32'(6));
            if (log_q.size() >= 1) check_eq("halt_last_pc", 32'(log_q[log_q.size()-1]), 32'h05);
            check_eq("halt_flag", 32'(halted), 32'(1));
            check_eq("halt_req_low", 32'(imem_req), 32'(0));
            tick(1'b1, 1'b1, 8'h10);
            log_q.delete();
            tick(1'b1, 1'b0, 8'h00);
            check_eq("halt_cleared", 32'(halted), 32'(0));
            wait_log(1, 1'b1);
            if (log_q.size() >= 1) check_eq("halt_resume_pc", 32'(log_q[0]), 32'h10);
            mem[5] = saved;
        end
`endif

        // Reset asserted while a request is outstanding
        lat_fixed = 3;
        for (int k = 0; k < 100; k++) begin
            tick(1'b1, 1'b0, 8'h00);
            if (imem_req && !imem_ack) break;
        end
        check_eq("mid_req_found", 32'(imem_req), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        wait_log(1, 1'b1);
        if (log_q.size() >= 1) check_eq("refetch_pc", 32'(log_q[0]), 32'(RESET_PC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
